// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, stall encoding,
// load lane-mask constants and bus payload structs.
package mem_stage_pkg;

    localparam int unsigned EX_TO_MEM_WD = 87;
    localparam int unsigned MEM_TO_WB_WD = 70;
    localparam int unsigned MEM_TO_RF_WD = 38;
    localparam int unsigned DATA_WD      = 32;
    localparam int unsigned MASK_WD      = 5;
    localparam int unsigned STALL_WD     = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int unsigned STALL_SELF    = 3;
    localparam int unsigned STALL_WB      = 4;
    localparam int unsigned MASK_SIGN_BIT = 4;

    // Lane masks as produced by execute; note the halfword/byte lane ordering.
    localparam logic [3:0] MASK_W  = 4'b1111;
    localparam logic [3:0] MASK_H0 = 4'b1100;
    localparam logic [3:0] MASK_H1 = 4'b0011;
    localparam logic [3:0] MASK_B0 = 4'b1000;
    localparam logic [3:0] MASK_B1 = 4'b0100;
    localparam logic [3:0] MASK_B2 = 4'b0010;
    localparam logic [3:0] MASK_B3 = 4'b0001;

    typedef struct packed {
        logic [MASK_WD-1:0] mask;
        logic [5:0]         opcode;
        logic [31:0]        pc;
        logic               sram_en;
        logic [3:0]         sram_wen;
        logic               sel_rf_res;
        logic               rf_we;
        logic [4:0]         rf_waddr;
        logic [DATA_WD-1:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic               rf_we;
        logic [4:0]         rf_waddr;
        logic [DATA_WD-1:0] rf_wdata;
    } mem_to_rf_t;

    typedef struct packed {
        logic [31:0] pc;
        mem_to_rf_t  rf;
    } mem_to_wb_t;

    typedef enum logic {
        HOLD_IDLE,
        HOLD_HELD
    } hold_state_e;

endpackage

// File: rtl/mem_stage_load_extract.sv
// Load data lane selection and sign/zero extension from a 32-bit read word.
module load_extract
    import mem_stage_pkg::*;
(
    input  logic [MASK_WD-1:0] mask,
    input  logic [DATA_WD-1:0] word,
    output logic [DATA_WD-1:0] value
);

    logic sgn;

    always_comb begin
        value = '0;
        sgn   = mask[MASK_SIGN_BIT];
        case (mask[3:0])
            MASK_W:  value = word;
            MASK_H0: value = {{16{sgn & word[15]}}, word[15:0]};
            MASK_H1: value = {{16{sgn & word[31]}}, word[31:16]};
            MASK_B0: value = {{24{sgn & word[7]}},  word[7:0]};
            MASK_B1: value = {{24{sgn & word[15]}}, word[15:8]};
            MASK_B2: value = {{24{sgn & word[23]}}, word[23:16]};
            MASK_B3: value = {{24{sgn & word[31]}}, word[31:24]};
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX->MEM pipeline register, load read-data hold across
// stalls, and packing of the write-back and forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [DATA_WD-1:0]      data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
    output logic                    mem_is_load
);

    ex_to_mem_t   bus_q, bus_d;
    hold_state_e  state_q;
    logic [DATA_WD-1:0] rdata_hold_q;
    logic         hold_valid;
    logic         bubble_c, reload_c, is_load_c, capture_c, release_c;
    logic [DATA_WD-1:0] rd_word_c, load_val_c;
    mem_to_rf_t   rf_c;
    mem_to_wb_t   wb_c;
    logic         unused_bits;

    assign bubble_c  = (stall[STALL_SELF] == STOP) && (stall[STALL_WB] == NO_STOP);
    assign reload_c  = (stall[STALL_SELF] == NO_STOP);
    assign is_load_c = bus_q.sel_rf_res & bus_q.sram_en;
    // A bubble on the same edge as a capture wins, so capture excludes it.
    assign capture_c = is_load_c && (stall[STALL_SELF] == STOP) && !bubble_c;
    assign release_c = reload_c || bubble_c;
    assign hold_valid = (state_q == HOLD_HELD);

    always_comb begin
        bus_d = bus_q;
        if (bubble_c) begin
            bus_d = '0;
        end else if (reload_c) begin
            bus_d = ex_to_mem_t'(ex_to_mem_bus);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q <= '0;
        end else begin
            bus_q <= bus_d;
        end
    end

    // Hold machine: freezes the first-cycle read data while this stage is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HOLD_IDLE;
            rdata_hold_q <= '0;
        end else begin
            case (state_q)
                HOLD_IDLE: begin
                    if (capture_c) begin
                        state_q      <= HOLD_HELD;
                        rdata_hold_q <= data_sram_rdata;
                    end
                end
                HOLD_HELD: begin
                    if (release_c) begin
                        state_q <= HOLD_IDLE;
                    end
                end
                default: state_q <= HOLD_IDLE;
            endcase
        end
    end

    assign rd_word_c = hold_valid ? rdata_hold_q : data_sram_rdata;

    load_extract u_load_extract (
        .mask  (bus_q.mask),
        .word  (rd_word_c),
        .value (load_val_c)
    );

    always_comb begin
        rf_c.rf_we    = bus_q.rf_we;
        rf_c.rf_waddr = bus_q.rf_waddr;
        rf_c.rf_wdata = bus_q.sel_rf_res ? load_val_c : bus_q.ex_result;
        wb_c.pc       = bus_q.pc;
        wb_c.rf       = rf_c;
    end

    assign mem_to_wb_bus = MEM_TO_WB_WD'(wb_c);
    assign mem_to_rf_bus = MEM_TO_RF_WD'(rf_c);
    assign mem_is_load   = is_load_c;

    assign unused_bits = ^{stall[5], stall[2:0], bus_q.opcode, bus_q.sram_wen};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: load extraction, stall hold,
// bubbles and reset during a held load.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [86:0] ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_rf_bus;
    logic        mem_is_load;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] ST_NONE   = 6'b000000;
    localparam logic [5:0] ST_STALL  = 6'b011000;
    localparam logic [5:0] ST_BUBBLE = 6'b001000;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_rf_bus   (mem_to_rf_bus),
        .mem_is_load     (mem_is_load)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [86:0] mk_ex(input logic [4:0] mask, input logic [31:0] pc,
                                          input logic sram_en, input logic [3:0] wen,
                                          input logic sel, input logic we,
                                          input logic [4:0] waddr, input logic [31:0] res);
        return {mask, 6'h23, pc, sram_en, wen, sel, we, waddr, res};
    endfunction

    function automatic logic [86:0] mk_load(input logic [4:0] mask, input logic [31:0] pc);
        return mk_ex(mask, pc, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5, 32'h0000_1000);
    endfunction

    function automatic logic [86:0] mk_alu(input logic [31:0] pc, input logic [31:0] res);
        return mk_ex(5'b0, pc, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, res);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Issue a load from EX, present rdata in MEM, and check the write data.
    task automatic do_load(input string tag, input logic [4:0] mask,
                           input logic [31:0] rdata, input logic [31:0] exp);
        ex_to_mem_bus = mk_load(mask, 32'h0000_0100);
        cyc();
        data_sram_rdata = rdata;
        settle();
        check(tag, 128'(mem_to_rf_bus), 128'({1'b1, 5'd5, exp}));
    endtask

    initial begin
        rst = 1'b1;
        stall = ST_NONE;
        ex_to_mem_bus = '0;
        data_sram_rdata = '0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        settle();
        check("reset_wb",      128'(mem_to_wb_bus), 128'(0));
        check("reset_rf",      128'(mem_to_rf_bus), 128'(0));
        check("reset_is_load", 128'(mem_is_load),   128'(0));
        check("reset_hold",    128'(dut.hold_valid), 128'(0));

        do_load("lb",  5'b1_0010, 32'h1280_3456, 32'hFFFF_FF80);
        check("lb_is_load", 128'(mem_is_load), 128'(1));
        check("lb_pc", 128'(mem_to_wb_bus[69:38]), 128'(32'h100));
        do_load("lbu", 5'b0_0010, 32'h1280_3456, 32'h0000_0080);
        do_load("lh",  5'b1_0011, 32'h8001_7FFF, 32'hFFFF_8001);
        do_load("lhu", 5'b0_1100, 32'h8001_7FFF, 32'h0000_7FFF);
        do_load("lw",  5'b1_1111, 32'h8001_7FFF, 32'h8001_7FFF);
        do_load("lb_b0s", 5'b1_1000, 32'h0000_00F0, 32'hFFFF_FFF0);
        do_load("lb_b1u", 5'b0_0100, 32'h0000_A500, 32'h0000_00A5);
        do_load("lb_b3s", 5'b1_0001, 32'h9A00_0000, 32'hFFFF_FF9A);
        do_load("bad_mask", 5'b1_0101, 32'hFFFF_FFFF, 32'h0000_0000);

        ex_to_mem_bus = mk_alu(32'h0000_0180, 32'h0000_1234);
        data_sram_rdata = 32'hDEAD_BEEF;
        cyc();
        settle();
        check("alu_rf", 128'(mem_to_rf_bus), 128'({1'b1, 5'd9, 32'h0000_1234}));
        check("alu_is_load", 128'(mem_is_load), 128'(0));
        ex_to_mem_bus = mk_ex(5'b0_1111, 32'h0000_0184, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_2000);
        cyc();
        settle();
        check("store_rf", 128'(mem_to_rf_bus), 128'({1'b0, 5'd0, 32'h0000_2000}));
        check("store_is_load", 128'(mem_is_load), 128'(0));

        // Load stalled three cycles with changing SRAM data.
        ex_to_mem_bus = mk_load(5'b1_1111, 32'h0000_0200);
        cyc();
        ex_to_mem_bus = mk_alu(32'h0000_0300, 32'h0000_0033);
        stall = ST_STALL;
        data_sram_rdata = 32'hAAAA_5555;
        settle();
        check("stall_c1_data", 128'(mem_to_rf_bus[31:0]), 128'(32'hAAAA_5555));
        check("stall_c1_hold", 128'(dut.hold_valid), 128'(0));
        cyc();
        data_sram_rdata = 32'h1111_1111;
        settle();
        check("stall_c2_data", 128'(mem_to_rf_bus[31:0]), 128'(32'hAAAA_5555));
        check("stall_c2_hold", 128'(dut.hold_valid), 128'(1));
        check("stall_c2_pc", 128'(mem_to_wb_bus[69:38]), 128'(32'h200));
        cyc();
        data_sram_rdata = 32'h2222_2222;
        settle();
        check("stall_c3_data", 128'(mem_to_rf_bus[31:0]), 128'(32'hAAAA_5555));
        check("stall_c3_hold", 128'(dut.hold_valid), 128'(1));
        cyc();
        stall = ST_NONE;
        data_sram_rdata = 32'h3333_3333;
        settle();
        check("stall_c4_data", 128'(mem_to_rf_bus[31:0]), 128'(32'hAAAA_5555));
        check("stall_c4_hold", 128'(dut.hold_valid), 128'(1));
        cyc();
        settle();
        check("release_hold", 128'(dut.hold_valid), 128'(0));
        check("release_wb", 128'(mem_to_wb_bus), 128'({32'h300, 1'b1, 5'd9, 32'h0000_0033}));

        // Bubble: own stage stops while write-back runs.
        ex_to_mem_bus = mk_alu(32'h0000_0400, 32'h0000_0077);
        stall = ST_BUBBLE;
        cyc();
        settle();
        check("bubble_wb", 128'(mem_to_wb_bus), 128'(0));
        stall = ST_NONE;
        cyc();
        settle();
        check("after_bubble_wb", 128'(mem_to_wb_bus), 128'({32'h400, 1'b1, 5'd9, 32'h0000_0077}));

        // Bubble on the same edge a load would capture.
        ex_to_mem_bus = mk_load(5'b1_1111, 32'h0000_0440);
        cyc();
        stall = ST_BUBBLE;
        data_sram_rdata = 32'h4444_4444;
        cyc();
        settle();
        check("bubble_vs_capture_hold", 128'(dut.hold_valid), 128'(0));
        check("bubble_vs_capture_wb", 128'(mem_to_wb_bus), 128'(0));
        stall = ST_NONE;

        // Reset while a load is held.
        ex_to_mem_bus = mk_load(5'b1_1111, 32'h0000_0500);
        cyc();
        stall = ST_STALL;
        data_sram_rdata = 32'h5555_5555;
        cyc();
        settle();
        check("pre_rst_hold", 128'(dut.hold_valid), 128'(1));
        rst = 1'b1;
        cyc();
        settle();
        check("rst_mid_wb", 128'(mem_to_wb_bus), 128'(0));
        check("rst_mid_rf", 128'(mem_to_rf_bus), 128'(0));
        check("rst_mid_hold", 128'(dut.hold_valid), 128'(0));
        check("rst_mid_rdata_hold", 128'(dut.rdata_hold_q), 128'(0));
        rst = 1'b0;
        stall = ST_NONE;
        ex_to_mem_bus = mk_load(5'b0_1100, 32'h0000_0600);
        cyc();
        data_sram_rdata = 32'h0000_BEEF;
        settle();
        check("post_rst_live", 128'(mem_to_rf_bus), 128'({1'b1, 5'd5, 32'h0000_BEEF}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage. Registers the execute-to-memory bus and obeys the shared stall vector. Extracts and sign/zero-extends load data from the synchronous data SRAM, and holds returned read data across back-pressure stalls. Drives the write-back bus and the memory-stage forwarding bus back to decode.

## Interface
- EX_TO_MEM_WD, 87: width of `ex_to_mem_bus`.
- MEM_TO_WB_WD, 70: width of `mem_to_wb_bus`.
- MEM_TO_RF_WD, 38: width of `mem_to_rf_bus`.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  6  pipeline stall vector; this stage uses bit 3 (own) and bit 4 (write-back).
- ex_to_mem_bus  in  87  fields:
  - [86:82] load mask {signed, lane[3:0]}
  - [81:76] opcode
  - [75:44] pc
  - [43] sram_en
  - [42:39] sram_wen
  - [38] sel_rf_res (1 = load result)
  - [37] rf_we
  - [36:32] rf_waddr
  - [31:0] ex_result
- data_sram_rdata  in  32  SRAM read data, valid the cycle after the address was issued in execute.
- mem_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- mem_to_rf_bus  out  38  {rf_we, rf_waddr, rf_wdata}, same values as the write-back fields, for forwarding.
- mem_is_load  out  1  the registered instruction is a load (sel_rf_res & sram_en).

## Operation
- Pipeline register `bus_r`, updated on clk with this priority:
  - rst: cleared to 0.
  - stall[3]=Stop and stall[4]=NoStop: cleared to 0 (inserts a bubble).
  - stall[3]=NoStop: loads `ex_to_mem_bus`.
  - Otherwise: holds its value.
- Lane mask from `bus_r[85:82]`, selecting a slice of the effective read word:
  - 1111: word [31:0].
  - 1100: halfword [15:0].
  - 0011: halfword [31:16].
  - 1000: byte [7:0].
  - 0100: byte [15:8].
  - 0010: byte [23:16].
  - 0001: byte [31:24].
  - Any other value: result 0.
- Extension: mask bit 4 = 1 sign-extends the selected halfword or byte to 32 bits; bit 4 = 0 zero-extends it. A word load ignores bit 4.
- rf_wdata = extracted load value when sel_rf_res=1, otherwise ex_result. Stores pass ex_result with rf_we=0.
- Read-data hold. Registers `rdata_hold[31:0]` and `hold_valid`:
  - Effective read word = hold_valid ? rdata_hold : data_sram_rdata.
  - Capture: on a clock edge where `bus_r` holds a load, hold_valid=0 and stall[3]=Stop, set rdata_hold ← data_sram_rdata and hold_valid ← 1.
  - Release: hold_valid clears on any edge where `bus_r` is reloaded or bubbled, and on rst.
  - While hold_valid=1, rdata_hold never changes.
- Two-state hold machine:
  - IDLE → HELD when the capture condition is met.
  - HELD → IDLE when stall[3]=NoStop, on a bubble, or on rst.
- No arithmetic beyond extension. All outputs are combinational from `bus_r` and the read word.

## Timing
- Latency: one cycle from `ex_to_mem_bus` to `mem_to_wb_bus`.
- Reset:
  - `bus_r`=0, so all outputs are 0: rf_we=0, pc=0, wdata=0, mem_is_load=0.
  - rdata_hold=0, hold_valid=0.
- Load timing: the SRAM address is issued in execute at cycle N. Read data is used combinationally in MEM at cycle N+1. For a stall of k cycles, the same data is presented for k+1 cycles.
- Simultaneous bubble and capture on the same edge: the bubble wins, so hold_valid=0.
- Reset mid-stall: hold and register clear on the next edge. No held data survives.
- Non-load instructions never set hold_valid.

## Structure
- Shared defines file (existing) gains:
  - EX_TO_MEM_WD, MEM_TO_WB_WD, MEM_TO_RF_WD.
  - Stop/NoStop (already present).
  - Named lane-mask constants: MASK_W, MASK_H0, MASK_H1, MASK_B0..MASK_B3, and the signed bit position.
- One combinational sub-module `load_extract`: inputs mask[4:0] and word[31:0], output value[31:0]. Lane select and extension live only there.
- The top module holds the pipeline register, the hold machine and the bus packing.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then idle → all outputs 0, mem_is_load=0.
- lb with mask 1_0010, rdata 0x12_80_34_56 → rf_wdata 0xFFFFFF80; lbu with mask 0_0010 → 0x00000080.
- lh with mask 1_0011, rdata 0x8001_7FFF → 0xFFFF8001; lhu with mask 0_1100 → 0x00007FFF; lw with mask 1_1111 → 0x80017FFF.
- Load stalled 3 cycles:
  - stall[3]=stall[4]=Stop, data_sram_rdata changes each cycle after the first.
  - Required: rf_wdata stays at the first-cycle value; hold_valid=1 for the last 3 cycles and clears on release.
- Bubble: stall[3]=Stop, stall[4]=NoStop with a valid add in execute → next cycle rf_we=0 and pc=0; the add appears once stall[3]=NoStop.
- rst asserted during a held load → next cycle all outputs 0 and hold_valid=0; the following load uses live rdata.
